// File: rtl/sync_pkg.sv
// Shared types and constants for the command execution stage.
// The command struct mirrors the upstream field order, TIME_START first.
package sync_pkg;

  localparam int TW = 64;
  localparam int FW = 48;
  localparam int CW = 32;

  typedef enum logic [1:0] {
    IMP_CW       = 2'b00,
    IMP_LFM_UP   = 2'b01,
    IMP_LFM_DOWN = 2'b10,
    IMP_RSVD     = 2'b11
  } impulse_type_e;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_CHECK = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } exec_state_e;

  typedef struct packed {
    logic [TW-1:0] time_start;
    logic [FW-1:0] freq;
    logic [FW-1:0] freq_step;
    logic [CW-1:0] freq_rate;
    logic [15:0]   n_impulse;
    impulse_type_e type_impulse;
    logic [CW-1:0] interval_ti;
    logic [CW-1:0] interval_tp;
    logic [CW-1:0] tblank1;
    logic [CW-1:0] tblank2;
  } cmd_t;

  typedef struct packed {
    logic impulse;
    logic blank;
  } gates_t;

  // Region bounds widened by two bits so Tb1+Ti+Tb2 can never wrap.
  function automatic gates_t phase_gates(input logic [CW-1:0] p, input cmd_t c);
    logic [CW+1:0] ph, b1, e1, e2;
    ph = {2'b00, p};
    b1 = {2'b00, c.tblank1};
    e1 = b1 + {2'b00, c.interval_ti};
    e2 = e1 + {2'b00, c.tblank2};
    phase_gates.impulse = (ph >= b1) && (ph < e1);
    phase_gates.blank   = (ph < b1) || ((ph >= e1) && (ph < e2));
  endfunction

endpackage

// File: rtl/cmd_exec_lfm_accum.sv
// DDS frequency register with a rate counter for stepped LFM ramps.
// load wins over run; every change of DDS_FREQ is flagged with a one-cycle VALID.
module lfm_accum
  import sync_pkg::*;
(
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          load,
  input  logic          run,
  input  logic          dir,
  input  logic [FW-1:0] FREQ,
  input  logic [FW-1:0] FREQ_STEP,
  input  logic [CW-1:0] FREQ_RATE,
  output logic [FW-1:0] DDS_FREQ,
  output logic          DDS_FREQ_VALID
);

  logic [CW-1:0] rate_cnt;
  logic [CW-1:0] rate_last;

  // A zero rate behaves as one step per cycle.
  assign rate_last = (FREQ_RATE == '0) ? '0 : FREQ_RATE - CW'(1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      DDS_FREQ       <= '0;
      DDS_FREQ_VALID <= 1'b0;
      rate_cnt       <= '0;
    end else begin
      DDS_FREQ_VALID <= 1'b0;
      if (load) begin
        DDS_FREQ       <= FREQ;
        rate_cnt       <= '0;
        DDS_FREQ_VALID <= 1'b1;
      end else if (run) begin
        if (rate_cnt == rate_last) begin
          rate_cnt       <= '0;
          DDS_FREQ       <= dir ? (DDS_FREQ - FREQ_STEP) : (DDS_FREQ + FREQ_STEP);
          DDS_FREQ_VALID <= 1'b1;
        end else begin
          rate_cnt <= rate_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cmd_exec.sv
// Execution stage: fetches a scheduled command, waits for its start time and
// plays out blanking/impulse gating periods while steering the DDS frequency.
module cmd_exec
  import sync_pkg::*;
(
  input  logic          CLK,
  input  logic          rst_n,
  input  logic [TW-1:0] TIME,
  input  logic          ABORT,
  input  logic          DATA_WR,
  input  logic [FW-1:0] FREQ,
  input  logic [FW-1:0] FREQ_STEP,
  input  logic [CW-1:0] FREQ_RATE,
  input  logic [TW-1:0] TIME_START,
  input  logic [15:0]   N_impulse,
  input  logic [1:0]    TYPE_impulse,
  input  logic [CW-1:0] Interval_Ti,
  input  logic [CW-1:0] Interval_Tp,
  input  logic [CW-1:0] Tblank1,
  input  logic [CW-1:0] Tblank2,
  output logic          REQ_COMM,
  output logic          IMPULSE,
  output logic          BLANK,
  output logic [FW-1:0] DDS_FREQ,
  output logic          DDS_FREQ_VALID,
  output logic          BUSY,
  output logic          CMD_DONE,
  output logic          CMD_LATE,
  output exec_state_e   dbg_state
);

  // Handshake: REQ_COMM is a level held high in REQ; DATA_WR is a one-cycle
  // strobe accepted only in REQ with ABORT low; acceptance drops REQ_COMM on
  // the same edge that captures the fields.

  exec_state_e   state, state_next;
  cmd_t          cmd;
  logic [CW-1:0] p, p_next, tp_last;
  logic [15:0]   n, n_next;
  logic          req_next, done_next, late_next, capture, enter;
  logic          wrap, last, lfm_type, load, run;
  gates_t        gates_next;

  assign tp_last  = (cmd.interval_tp == '0) ? '0 : cmd.interval_tp - CW'(1);
  assign wrap     = (p == tp_last);
  assign last     = (cmd.n_impulse == 16'd0) || (wrap && (n == cmd.n_impulse - 16'd1));
  assign lfm_type = (cmd.type_impulse == IMP_LFM_UP) || (cmd.type_impulse == IMP_LFM_DOWN);

  always_comb begin
    state_next = state;
    p_next     = p;
    n_next     = n;
    req_next   = 1'b0;
    done_next  = 1'b0;
    late_next  = 1'b0;
    capture    = 1'b0;
    enter      = 1'b0;
    if (ABORT) begin
      state_next = ST_REQ;
    end else begin
      case (state)
        ST_REQ: begin
          if (DATA_WR) begin
            capture    = 1'b1;
            state_next = ST_CHECK;
          end else begin
            req_next = 1'b1;
          end
        end
        ST_CHECK: begin
          if (cmd.time_start <= TIME) begin
            late_next  = 1'b1;
            state_next = ST_REQ;
          end else begin
            state_next = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (TIME >= cmd.time_start) begin
            state_next = ST_RUN;
            p_next     = '0;
            n_next     = '0;
            enter      = 1'b1;
          end
        end
        ST_RUN: begin
          if (last) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            enter  = 1'b1;
            p_next = wrap ? '0 : p + CW'(1);
            n_next = wrap ? n + 16'd1 : n;
          end
        end
        ST_DONE: state_next = ST_REQ;
        default: state_next = ST_REQ;
      endcase
    end
  end

  // Gates and DDS control are derived from the phase about to be displayed.
  always_comb begin
    gates_next = '0;
    load       = 1'b0;
    run        = 1'b0;
    if (enter && (cmd.n_impulse != 16'd0)) begin
      gates_next = phase_gates(p_next, cmd);
      load       = (p_next == cmd.tblank1);
      run        = lfm_type && gates_next.impulse && !load;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      cmd      <= '0;
      p        <= '0;
      n        <= '0;
      REQ_COMM <= 1'b0;
      IMPULSE  <= 1'b0;
      BLANK    <= 1'b0;
      CMD_DONE <= 1'b0;
      CMD_LATE <= 1'b0;
    end else begin
      state    <= state_next;
      p        <= p_next;
      n        <= n_next;
      REQ_COMM <= req_next;
      IMPULSE  <= gates_next.impulse;
      BLANK    <= gates_next.blank;
      CMD_DONE <= done_next;
      CMD_LATE <= late_next;
      if (capture) begin
        cmd.time_start   <= TIME_START;
        cmd.freq         <= FREQ;
        cmd.freq_step    <= FREQ_STEP;
        cmd.freq_rate    <= FREQ_RATE;
        cmd.n_impulse    <= N_impulse;
        cmd.type_impulse <= impulse_type_e'(TYPE_impulse);
        cmd.interval_ti  <= Interval_Ti;
        cmd.interval_tp  <= Interval_Tp;
        cmd.tblank1      <= Tblank1;
        cmd.tblank2      <= Tblank2;
      end
    end
  end

  assign BUSY      = (state == ST_ARMED) || (state == ST_RUN);
  assign dbg_state = state;

  lfm_accum u_lfm (
    .CLK            (CLK),
    .rst_n          (rst_n),
    .load           (load),
    .run            (run),
    .dir            (cmd.type_impulse == IMP_LFM_DOWN),
    .FREQ           (cmd.freq),
    .FREQ_STEP      (cmd.freq_step),
    .FREQ_RATE      (cmd.freq_rate),
    .DDS_FREQ       (DDS_FREQ),
    .DDS_FREQ_VALID (DDS_FREQ_VALID)
  );

endmodule

// File: tb/tb_cmd_exec.sv
// Bench for cmd_exec: every output change is an event {kind, TIME stamp, value}
// matched in order against hand-computed events queued by the stimulus.
module tb_cmd_exec;
  import sync_pkg::*;

  localparam int EW      = 4 + TW + FW;
  localparam int EV_REQ  = 1;
  localparam int EV_BUSY = 2;
  localparam int EV_GATE = 3;
  localparam int EV_FREQ = 4;
  localparam int EV_DONE = 5;
  localparam int EV_LATE = 6;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic [TW-1:0] TIME;
  logic          ABORT, DATA_WR;
  logic [FW-1:0] FREQ, FREQ_STEP;
  logic [CW-1:0] FREQ_RATE;
  logic [TW-1:0] TIME_START;
  logic [15:0]   N_impulse;
  logic [1:0]    TYPE_impulse;
  logic [CW-1:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic          REQ_COMM, IMPULSE, BLANK, DDS_FREQ_VALID, BUSY, CMD_DONE, CMD_LATE;
  logic [FW-1:0] DDS_FREQ;
  exec_state_e   dbg_state;

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  cmd_exec dut (
    .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .ABORT(ABORT), .DATA_WR(DATA_WR),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START),
    .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
    .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2),
    .REQ_COMM(REQ_COMM), .IMPULSE(IMPULSE), .BLANK(BLANK), .DDS_FREQ(DDS_FREQ),
    .DDS_FREQ_VALID(DDS_FREQ_VALID), .BUSY(BUSY), .CMD_DONE(CMD_DONE),
    .CMD_LATE(CMD_LATE), .dbg_state(dbg_state)
  );

  // ---------------- clock / system time ----------------
  initial forever #5 CLK = ~CLK;

  initial begin
    TIME = 64'd897;
    forever begin
      @(negedge CLK);
      TIME = TIME + 64'd1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  task automatic push(input int k, input logic [TW-1:0] st, input logic [FW-1:0] v);
    logic [3:0] kk;
    kk = k[3:0];
    exp_q.push_back({kk, st, v});
  endtask

  task automatic observe(input int k, input logic [TW-1:0] st, input logic [FW-1:0] v);
    logic [EW-1:0] got, want;
    logic [3:0]    kk;
    kk  = k[3:0];
    got = {kk, st, v};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d time=%0d val=0x%0h, required none", k, st, v);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL event: got kind=%0d time=%0d val=0x%0h, required kind=%0d time=%0d val=0x%0h",
                 k, st, v, want[EW-1 -: 4], want[FW +: TW], want[FW-1:0]);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, want);
    end
  endtask

  // Monitor: samples #1 after each active edge; stamp = TIME seen by that edge.
  initial begin
    logic       p_req, p_busy;
    logic [1:0] p_gate;
    p_req  = 1'b0;
    p_busy = 1'b0;
    p_gate = 2'b00;
    forever begin
      @(posedge CLK);
      #1;
      if (!rst_n) begin
        p_req  = 1'b0;
        p_busy = 1'b0;
        p_gate = 2'b00;
      end else begin
        if (REQ_COMM && !p_req)            observe(EV_REQ,  TIME, 48'd1);
        if (BUSY != p_busy)                observe(EV_BUSY, TIME, {47'd0, BUSY});
        if ({IMPULSE, BLANK} != p_gate)    observe(EV_GATE, TIME, {46'd0, IMPULSE, BLANK});
        if (DDS_FREQ_VALID)                observe(EV_FREQ, TIME, DDS_FREQ);
        if (CMD_DONE)                      observe(EV_DONE, TIME, 48'd0);
        if (CMD_LATE)                      observe(EV_LATE, TIME, 48'd0);
        p_req  = REQ_COMM;
        p_busy = BUSY;
        p_gate = {IMPULSE, BLANK};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  function automatic cmd_t mk(input logic [TW-1:0] ts, input logic [FW-1:0] f,
                              input logic [FW-1:0] fs, input logic [CW-1:0] rate,
                              input logic [15:0] num, input logic [1:0] typ,
                              input logic [CW-1:0] ti, input logic [CW-1:0] tp,
                              input logic [CW-1:0] b1, input logic [CW-1:0] b2);
    cmd_t c;
    c.time_start   = ts;
    c.freq         = f;
    c.freq_step    = fs;
    c.freq_rate    = rate;
    c.n_impulse    = num;
    c.type_impulse = impulse_type_e'(typ);
    c.interval_ti  = ti;
    c.interval_tp  = tp;
    c.tblank1      = b1;
    c.tblank2      = b2;
    return c;
  endfunction

  task automatic drive_fields(input cmd_t c);
    TIME_START   = c.time_start;
    FREQ         = c.freq;
    FREQ_STEP    = c.freq_step;
    FREQ_RATE    = c.freq_rate;
    N_impulse    = c.n_impulse;
    TYPE_impulse = c.type_impulse;
    Interval_Ti  = c.interval_ti;
    Interval_Tp  = c.interval_tp;
    Tblank1      = c.tblank1;
    Tblank2      = c.tblank2;
  endtask

  task automatic send(input cmd_t c);
    drive_fields(c);
    DATA_WR = 1'b1;
    step();
    DATA_WR = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!REQ_COMM && k < 400) begin
      step();
      k++;
    end
    if (!REQ_COMM) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_req_timeout: got REQ_COMM=0, required 1", tag);
    end
  endtask

  task automatic wait_time(input logic [TW-1:0] target);
    int k;
    k = 0;
    while (TIME != target && k < 400) begin
      step();
      k++;
    end
    if (TIME != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_time: got TIME=%0d, required %0d", TIME, target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TW-1:0] tw, s, b;
    rst_n   = 1'b0;
    ABORT   = 1'b0;
    DATA_WR = 1'b0;
    drive_fields('0);
    #2;
    chk("reset_req_comm", {63'd0, REQ_COMM}, 64'd0);
    chk("reset_gates",    {62'd0, IMPULSE, BLANK}, 64'd0);
    chk("reset_busy",     {63'd0, BUSY}, 64'd0);
    chk("reset_dds",      {16'd0, DDS_FREQ}, 64'd0);
    chk("reset_strobes",  {61'd0, DDS_FREQ_VALID, CMD_DONE, CMD_LATE}, 64'd0);

    push(EV_REQ, 64'd900, 48'd1);
    step(); step(); step();
    rst_n = 1'b1;
    wait_req("t1_pre");

    // 1: CW command starting at 1000, three 20-cycle periods.
    tw = TIME;
    push(EV_BUSY, tw + 1, 48'd1);
    for (int k = 0; k < 3; k++) begin
      b = 64'd1000 + 64'(20 * k);
      push(EV_GATE, b,      48'd1);
      push(EV_GATE, b + 2,  48'd2);
      push(EV_FREQ, b + 2,  48'h123);
      push(EV_GATE, b + 7,  48'd1);
      push(EV_GATE, b + 10, 48'd0);
    end
    push(EV_BUSY, 64'd1060, 48'd0);
    push(EV_DONE, 64'd1060, 48'd0);
    push(EV_REQ,  64'd1062, 48'd1);
    send(mk(64'd1000, 48'h123, 48'd0, 32'd0, 16'd3, 2'b00, 32'd5, 32'd20, 32'd2, 32'd3));
    wait_req("t1");

    // 2: LFM up, steps every 2 cycles inside a 7-cycle impulse.
    tw = TIME;
    s  = tw + 10;
    push(EV_BUSY, tw + 1, 48'd1);
    for (int k = 0; k < 2; k++) begin
      b = s + 64'(12 * k);
      push(EV_GATE, b,      48'd1);
      push(EV_GATE, b + 1,  48'd2);
      push(EV_FREQ, b + 1,  48'd100);
      push(EV_FREQ, b + 3,  48'd110);
      push(EV_FREQ, b + 5,  48'd120);
      push(EV_FREQ, b + 7,  48'd130);
      push(EV_GATE, b + 8,  48'd1);
      push(EV_GATE, b + 10, 48'd0);
    end
    push(EV_BUSY, s + 24, 48'd0);
    push(EV_DONE, s + 24, 48'd0);
    push(EV_REQ,  s + 26, 48'd1);
    send(mk(s, 48'd100, 48'd10, 32'd2, 16'd2, 2'b01, 32'd7, 32'd12, 32'd1, 32'd2));
    wait_req("t2");

    // 3: LFM down wraps below zero.
    tw = TIME;
    s  = tw + 10;
    push(EV_BUSY, tw + 1, 48'd1);
    push(EV_GATE, s,      48'd2);
    push(EV_FREQ, s,      48'd5);
    push(EV_FREQ, s + 1,  48'hFFFF_FFFF_FFFB);
    push(EV_FREQ, s + 2,  48'hFFFF_FFFF_FFF1);
    push(EV_GATE, s + 3,  48'd0);
    push(EV_BUSY, s + 4,  48'd0);
    push(EV_DONE, s + 4,  48'd0);
    push(EV_REQ,  s + 6,  48'd1);
    send(mk(s, 48'd5, 48'd10, 32'd1, 16'd1, 2'b10, 32'd3, 32'd4, 32'd0, 32'd0));
    wait_req("t3");

    // 4: expired start times (already past, and equal at the check edge).
    tw = TIME;
    push(EV_LATE, tw + 1, 48'd0);
    push(EV_REQ,  tw + 2, 48'd1);
    send(mk(tw - 1, 48'h1, 48'd0, 32'd0, 16'd2, 2'b00, 32'd3, 32'd8, 32'd1, 32'd1));
    wait_req("t4a");
    tw = TIME;
    push(EV_LATE, tw + 1, 48'd0);
    push(EV_REQ,  tw + 2, 48'd1);
    send(mk(tw + 1, 48'h2, 48'd0, 32'd0, 16'd2, 2'b00, 32'd3, 32'd8, 32'd1, 32'd1));
    wait_req("t4b");

    // 6a: N=0 with the earliest non-late start.
    tw = TIME;
    push(EV_BUSY, tw + 1, 48'd1);
    push(EV_BUSY, tw + 3, 48'd0);
    push(EV_DONE, tw + 3, 48'd0);
    push(EV_REQ,  tw + 5, 48'd1);
    send(mk(tw + 2, 48'h3, 48'd0, 32'd0, 16'd0, 2'b00, 32'd3, 32'd8, 32'd0, 32'd1));
    wait_req("t6a");

    // 5: ABORT mid-impulse of the second period; DATA_WR during ABORT is dropped.
    tw = TIME;
    s  = tw + 10;
    push(EV_BUSY, tw + 1, 48'd1);
    push(EV_GATE, s,      48'd1);
    push(EV_GATE, s + 1,  48'd2);
    push(EV_FREQ, s + 1,  48'h55);
    push(EV_GATE, s + 5,  48'd1);
    push(EV_GATE, s + 6,  48'd0);
    push(EV_GATE, s + 8,  48'd1);
    push(EV_GATE, s + 9,  48'd2);
    push(EV_FREQ, s + 9,  48'h55);
    push(EV_BUSY, s + 10, 48'd0);
    push(EV_GATE, s + 10, 48'd0);
    push(EV_REQ,  s + 13, 48'd1);
    send(mk(s, 48'h55, 48'd0, 32'd0, 16'd3, 2'b00, 32'd4, 32'd8, 32'd1, 32'd1));
    wait_time(s + 10);
    ABORT = 1'b1;
    step();
    drive_fields(mk(s + 30, 48'h66, 48'd0, 32'd0, 16'd1, 2'b00, 32'd2, 32'd4, 32'd0, 32'd0));
    DATA_WR = 1'b1;
    step();
    DATA_WR = 1'b0;
    step();
    ABORT = 1'b0;
    wait_req("t5");

    // 6b: Tp=0 acts as one-cycle periods, reloading every cycle.
    tw = TIME;
    s  = tw + 10;
    push(EV_BUSY, tw + 1, 48'd1);
    push(EV_GATE, s,      48'd2);
    push(EV_FREQ, s,      48'h77);
    push(EV_FREQ, s + 1,  48'h77);
    push(EV_FREQ, s + 2,  48'h77);
    push(EV_BUSY, s + 3,  48'd0);
    push(EV_GATE, s + 3,  48'd0);
    push(EV_DONE, s + 3,  48'd0);
    push(EV_REQ,  s + 5,  48'd1);
    send(mk(s, 48'h77, 48'd0, 32'd0, 16'd3, 2'b00, 32'd1, 32'd0, 32'd0, 32'd0));
    wait_req("t6b");

    // 6c: impulse runs past Tp (truncated), FREQ_RATE=0 steps every cycle.
    tw = TIME;
    s  = tw + 10;
    push(EV_BUSY, tw + 1, 48'd1);
    for (int k = 0; k < 2; k++) begin
      b = s + 64'(6 * k);
      push(EV_GATE, b,     48'd1);
      push(EV_GATE, b + 2, 48'd2);
      push(EV_FREQ, b + 2, 48'd1000);
      push(EV_FREQ, b + 3, 48'd1001);
      push(EV_FREQ, b + 4, 48'd1002);
      push(EV_FREQ, b + 5, 48'd1003);
    end
    push(EV_BUSY, s + 12, 48'd0);
    push(EV_GATE, s + 12, 48'd0);
    push(EV_DONE, s + 12, 48'd0);
    push(EV_REQ,  s + 14, 48'd1);
    send(mk(s, 48'd1000, 48'd1, 32'd0, 16'd2, 2'b01, 32'd10, 32'd6, 32'd2, 32'd3));
    wait_req("t6c");

    // 6d: asynchronous reset in the middle of an impulse.
    tw = TIME;
    s  = tw + 10;
    push(EV_BUSY, tw + 1, 48'd1);
    push(EV_GATE, s,      48'd2);
    push(EV_FREQ, s,      48'h99);
    push(EV_REQ,  s + 4,  48'd1);
    send(mk(s, 48'h99, 48'd0, 32'd0, 16'd2, 2'b00, 32'd5, 32'd10, 32'd0, 32'd0));
    wait_time(s + 2);
    chk("pre_reset_impulse", {63'd0, IMPULSE}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_gates", {62'd0, IMPULSE, BLANK}, 64'd0);
    chk("async_reset_dds",   {16'd0, DDS_FREQ}, 64'd0);
    chk("async_reset_busy",  {63'd0, BUSY}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    wait_req("t6d");

    // ---------------- final report ----------------
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_events: got %0d events unseen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
